// File: rtl/cache_pkg.sv
// Shared geometry, address slicing and FSM state encoding for the
// direct-mapped write-back cache controller.
package cache_pkg;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BLOCK_W  = 128;
  localparam int unsigned NBLOCKS  = 4;
  localparam int unsigned WORDS    = BLOCK_W / WORD_W;

  localparam int unsigned TAG_MSB   = 9;
  localparam int unsigned TAG_LSB   = 6;
  localparam int unsigned TAG_W     = TAG_MSB - TAG_LSB + 1;
  localparam int unsigned INDEX_MSB = 5;
  localparam int unsigned INDEX_LSB = 4;
  localparam int unsigned INDEX_W   = INDEX_MSB - INDEX_LSB + 1;
  localparam int unsigned WORD_MSB  = 3;
  localparam int unsigned WORD_LSB  = 2;
  localparam int unsigned WSEL_W    = WORD_MSB - WORD_LSB + 1;
  localparam int unsigned OFFSET_W  = INDEX_LSB;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef logic [WORDS-1:0][WORD_W-1:0] block_t;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE,
    DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0]   tag,
                                                   input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_store.sv
// Tag, valid, dirty and data arrays for the direct-mapped cache.
// Valid/dirty clear on reset; tag and data contents are left unreset.
module cache_store
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  output block_t             rd_block,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_block,
  input  logic               word_we,
  input  logic [WSEL_W-1:0]  word_sel,
  input  logic [WORD_W-1:0]  word_data,
  input  logic               dirty_set,
  input  logic               dirty_clr
);

  block_t             data_q  [NBLOCKS];
  logic [TAG_W-1:0]   tag_q   [NBLOCKS];
  logic [NBLOCKS-1:0] valid_q;
  logic [NBLOCKS-1:0] dirty_q;

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[index] <= fill_block;
      tag_q[index]  <= fill_tag;
    end else if (word_we) begin
      data_q[index][word_sel] <= word_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en)
        valid_q[index] <= 1'b1;
      if (dirty_clr)
        dirty_q[index] <= 1'b0;
      else if (dirty_set)
        dirty_q[index] <= 1'b1;
    end
  end

  assign rd_block = data_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Write-back, write-allocate direct-mapped cache controller: request latch,
// hit/write-back/refill FSM and registered CPU/memory-side outputs.
module dm_cache_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_read_write,
  input  logic [ADDR_W-1:0]  cpu_address,
  input  logic [WORD_W-1:0]  cpu_write_data,
  output logic [WORD_W-1:0]  cpu_read_data,
  output logic               cpu_ready,
  output logic               hit_miss,
  output logic               dm_req,
  output logic               dm_read_write,
  output logic [ADDR_W-1:0]  dm_address,
  output logic [BLOCK_W-1:0] dm_write_data,
  input  logic [BLOCK_W-1:0] dm_read_data,
  input  logic               dm_ready
);

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   lat_tag_q;
  logic [INDEX_W-1:0] lat_idx_q;
  logic [WSEL_W-1:0]  lat_word_q;
  logic               lat_rw_q;
  logic [WORD_W-1:0]  lat_wdata_q;
  logic               miss_q;

  block_t             rd_block;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid;
  logic               rd_dirty;
  logic               hit;
  logic               fill_en;
  logic               word_we;
  logic               dirty_set;
  logic               addr_unused;

  assign addr_unused = ^cpu_address[WORD_LSB-1:0];

  cache_store u_store (
    .clk        (clk),
    .reset      (reset),
    .index      (lat_idx_q),
    .rd_block   (rd_block),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .fill_en    (fill_en),
    .fill_tag   (lat_tag_q),
    .fill_block (dm_read_data),
    .word_we    (word_we),
    .word_sel   (lat_word_q),
    .word_data  (lat_wdata_q),
    .dirty_set  (dirty_set),
    .dirty_clr  (fill_en)
  );

  assign hit = rd_valid && (rd_tag == lat_tag_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A refill always returns to COMPARE so the write merge happens in one place.
  always_comb begin
    state_d   = state_q;
    fill_en   = 1'b0;
    word_we   = 1'b0;
    dirty_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          state_d = DONE;
          if (lat_rw_q == RW_WRITE) begin
            word_we   = 1'b1;
            dirty_set = 1'b1;
          end
        end else if (rd_valid && rd_dirty) begin
          state_d = WRITE_BACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (dm_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (dm_ready) begin
          fill_en = 1'b1;
          state_d = COMPARE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_tag_q   <= '0;
      lat_idx_q   <= '0;
      lat_word_q  <= '0;
      lat_rw_q    <= RW_READ;
      lat_wdata_q <= '0;
      miss_q      <= 1'b0;
    end else if (state_q == IDLE && cpu_req) begin
      lat_tag_q   <= cpu_address[TAG_MSB:TAG_LSB];
      lat_idx_q   <= cpu_address[INDEX_MSB:INDEX_LSB];
      lat_word_q  <= cpu_address[WORD_MSB:WORD_LSB];
      lat_rw_q    <= cpu_read_write;
      lat_wdata_q <= cpu_write_data;
      miss_q      <= 1'b0;
    end else if (state_q == COMPARE && !hit) begin
      miss_q <= 1'b1;
    end
  end

  // Outputs are registered from the next state so they are glitch-free Moore signals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_read_data <= '0;
      cpu_ready     <= 1'b0;
      hit_miss      <= 1'b0;
      dm_req        <= 1'b0;
      dm_read_write <= 1'b0;
      dm_address    <= '0;
      dm_write_data <= '0;
    end else begin
      if (state_q == COMPARE && hit && lat_rw_q == RW_READ)
        cpu_read_data <= rd_block[lat_word_q];
      cpu_ready     <= (state_d == DONE);
      hit_miss      <= (state_d == DONE) && !miss_q;
      dm_req        <= (state_d == WRITE_BACK) || (state_d == ALLOCATE);
      dm_read_write <= (state_d == WRITE_BACK);
      case (state_d)
        WRITE_BACK: begin
          dm_address    <= block_addr(rd_tag, lat_idx_q);
          dm_write_data <= rd_block;
        end
        ALLOCATE: begin
          dm_address    <= block_addr(lat_tag_q, lat_idx_q);
          dm_write_data <= '0;
        end
        default: begin
          dm_address    <= '0;
          dm_write_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: directed CPU accesses with hand-computed
// responses, a delay-programmable memory model, and queue-based checking.
module tb_dm_cache_ctrl;
  import cache_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_read_write = 1'b0;
  logic [9:0]   cpu_address = '0;
  logic [31:0]  cpu_write_data = '0;
  logic [31:0]  cpu_read_data;
  logic         cpu_ready;
  logic         hit_miss;
  logic         dm_req;
  logic         dm_read_write;
  logic [9:0]   dm_address;
  logic [127:0] dm_write_data;
  logic [127:0] dm_read_data = '0;
  logic         dm_ready;
  logic         mem_ready = 1'b0;
  logic         stray_ready = 1'b0;

  assign dm_ready = mem_ready | stray_ready;

  dm_cache_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_read_write (cpu_read_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .cpu_ready      (cpu_ready),
    .hit_miss       (hit_miss),
    .dm_req         (dm_req),
    .dm_read_write  (dm_read_write),
    .dm_address     (dm_address),
    .dm_write_data  (dm_write_data),
    .dm_read_data   (dm_read_data),
    .dm_ready       (dm_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rw;
    logic        hit;
    logic [31:0] rdata;
    int unsigned lat;
    int unsigned issue;
  } cpu_exp_t;

  typedef struct {
    logic         rw;
    logic [9:0]   addr;
    logic [127:0] wdata;
  } dm_exp_t;

  cpu_exp_t     cpu_q[$];
  dm_exp_t      dm_q[$];
  logic [127:0] mem [64];
  int unsigned  mem_delay = 1;
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_dm(input logic rw, input logic [9:0] addr, input logic [127:0] wd);
    dm_exp_t e;
    e.rw = rw; e.addr = addr; e.wdata = wd;
    dm_q.push_back(e);
  endtask

  // Memory responder: checks each request, answers after mem_delay cycles.
  task automatic serve();
    dm_exp_t    e;
    logic [5:0] blk;
    bit         dropped;
    logic       was_write;
    dropped   = 1'b0;
    blk       = dm_address[9:4];
    was_write = dm_read_write;
    if (dm_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL dm_unexpected: got rw=%b addr=%h expected no request", dm_read_write, dm_address);
    end else begin
      e = dm_q.pop_front();
      check("dm_read_write", {127'd0, dm_read_write}, {127'd0, e.rw});
      check("dm_address", {118'd0, dm_address}, {118'd0, e.addr});
      if (e.rw) check("dm_write_data", dm_write_data, e.wdata);
    end
    for (int i = 1; i < int'(mem_delay); i++) begin
      @(negedge clk);
      if (dm_req !== 1'b1) begin
        dropped = 1'b1;
        break;
      end
    end
    if (!dropped) begin
      mem_ready    = 1'b1;
      dm_read_data = mem[blk];
      if (was_write) mem[blk] = dm_write_data;
      @(negedge clk);
      mem_ready = 1'b0;
      if (!was_write) check("dm_req_drop", {127'd0, dm_req}, 128'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (dm_req === 1'b1) serve();
    end
  end

  always @(negedge clk) begin : cpu_monitor
    cpu_exp_t e;
    if (reset !== 1'b1 && cpu_ready === 1'b1) begin
      if (cpu_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL cpu_unexpected: got cpu_ready=1 expected no response");
      end else begin
        e = cpu_q.pop_front();
        check("hit_miss", {127'd0, hit_miss}, {127'd0, e.hit});
        if (e.rw == RW_READ) check("cpu_read_data", {96'd0, cpu_read_data}, {96'd0, e.rdata});
        check("latency", {96'd0, cyc - e.issue}, {96'd0, e.lat});
      end
    end
  end

  task automatic access(input logic rw, input logic [9:0] addr, input logic [31:0] wd,
                        input logic hit, input logic [31:0] rd, input int unsigned lat,
                        input bit perturb);
    cpu_exp_t e;
    bit       got;
    got = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_read_write = rw; cpu_address = addr; cpu_write_data = wd;
    e.rw = rw; e.hit = hit; e.rdata = rd; e.lat = lat; e.issue = cyc;
    cpu_q.push_back(e);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (perturb && i == 3) begin
        cpu_address = 10'h000; cpu_read_write = ~rw; cpu_write_data = 32'h0;
      end
      if (cpu_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0; cpu_read_write = 1'b0; cpu_address = '0; cpu_write_data = '0;
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL cpu_timeout: got no cpu_ready expected one for addr %h", addr);
      void'(cpu_q.pop_back());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++)
        mem[b][w*32 +: 32] = {16'hC0DE, 8'(b), 8'(w)};
    mem[0] = 128'h44444444_33333333_22222222_11111111;

    repeat (3) @(negedge clk);
    check("rst_dm_req", {127'd0, dm_req}, 128'd0);
    check("rst_dm_read_write", {127'd0, dm_read_write}, 128'd0);
    check("rst_dm_address", {118'd0, dm_address}, 128'd0);
    check("rst_dm_write_data", dm_write_data, 128'd0);
    check("rst_cpu_ready", {127'd0, cpu_ready}, 128'd0);
    check("rst_hit_miss", {127'd0, hit_miss}, 128'd0);
    check("rst_cpu_read_data", {96'd0, cpu_read_data}, 128'd0);
    reset = 1'b0;

    // Clean miss, then hits within the refilled block.
    mem_delay = 3;
    expect_dm(RW_READ, 10'h000, '0);
    access(RW_READ, 10'h004, '0, 1'b0, 32'h22222222, 6, 1'b0);
    access(RW_READ, 10'h008, '0, 1'b1, 32'h33333333, 2, 1'b0);
    access(RW_WRITE, 10'h00C, 32'hDEADBEEF, 1'b1, '0, 2, 1'b0);

    // Index 0 with tag 4 evicts the dirty line.
    mem_delay = 2;
    expect_dm(RW_WRITE, 10'h000, 128'hDEADBEEF_33333333_22222222_11111111);
    expect_dm(RW_READ, 10'h100, '0);
    access(RW_READ, 10'h10C, '0, 1'b0, 32'hC0DE1003, 7, 1'b0);

    mem_delay = 1;
    expect_dm(RW_READ, 10'h000, '0);
    access(RW_READ, 10'h000, '0, 1'b0, 32'h11111111, 4, 1'b0);
    access(RW_READ, 10'h00C, '0, 1'b1, 32'hDEADBEEF, 2, 1'b0);

    // Write miss to clean index 1, then its dirty eviction.
    mem_delay = 5;
    expect_dm(RW_READ, 10'h010, '0);
    access(RW_WRITE, 10'h014, 32'hCAFEF00D, 1'b0, '0, 8, 1'b0);
    access(RW_READ, 10'h014, '0, 1'b1, 32'hCAFEF00D, 2, 1'b0);
    mem_delay = 4;
    expect_dm(RW_WRITE, 10'h010, 128'hC0DE0103_C0DE0102_CAFEF00D_C0DE0100);
    expect_dm(RW_READ, 10'h050, '0);
    access(RW_READ, 10'h054, '0, 1'b0, 32'hC0DE0501, 11, 1'b0);

    repeat (3) begin
      @(negedge clk); stray_ready = 1'b1;
      @(negedge clk); stray_ready = 1'b0;
      check("stray_dm_req", {127'd0, dm_req}, 128'd0);
    end
    access(RW_READ, 10'h054, '0, 1'b1, 32'hC0DE0501, 2, 1'b0);

    // CPU inputs wander during the refill; the latched request must win.
    mem_delay = 8;
    expect_dm(RW_READ, 10'h0A0, '0);
    access(RW_READ, 10'h0A8, '0, 1'b0, 32'hC0DE0A02, 11, 1'b1);
    access(RW_READ, 10'h0A8, '0, 1'b1, 32'hC0DE0A02, 2, 1'b0);
    access(RW_READ, 10'h000, '0, 1'b1, 32'h11111111, 2, 1'b0);

    // Reset while ALLOCATE waits on memory.
    mem_delay = 20;
    expect_dm(RW_READ, 10'h030, '0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_read_write = RW_READ; cpu_address = 10'h034;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dm_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("alloc_started", {127'd0, seen}, 128'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_dm_req", {127'd0, dm_req}, 128'd0);
    check("reset_cpu_ready", {127'd0, cpu_ready}, 128'd0);
    cpu_req = 1'b0; cpu_address = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_delay = 2;
    expect_dm(RW_READ, 10'h000, '0);
    access(RW_READ, 10'h004, '0, 1'b0, 32'h22222222, 5, 1'b0);

    repeat (5) @(negedge clk);
    check("cpu_q_drained", 128'(cpu_q.size()), 128'd0);
    check("dm_q_drained", 128'(dm_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
